// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the badge UART command transmitter.
// UART_CMD_TX_CHECKSUM_EN adds a fourth (checksum) byte to every frame.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        BT_IDLE,
        BT_START,
        BT_DATA,
        BT_STOP
    } byte_state_t;

    typedef enum logic [1:0] {
        SEQ_IDLE,
        SEQ_SEND,
        SEQ_GAP
    } seq_state_t;

    localparam logic [7:0] MODE_SHOOTING_FLAGS = 8'h41;
    localparam logic [7:0] MODE_AES_KEY_STORE  = 8'h42;
    localparam logic [7:0] ARG_RESET           = 8'h60;

`ifdef UART_CMD_TX_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 4;
`else
    localparam int unsigned FRAME_LEN = 3;
`endif

    // Frame layout: mode, arg, mode (endchar-framed), optional checksum.
    function automatic logic [7:0] frame_byte(input logic [2:0] idx,
                                              input logic [7:0] mode,
                                              input logic [7:0] arg);
        logic [7:0] b;
        b = mode;
        case (idx)
            3'd1:    b = arg;
`ifdef UART_CMD_TX_CHECKSUM_EN
            3'd3:    b = mode ^ arg ^ mode;
`endif
            default: b = mode;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer with valid/ready input; accepts the next byte on the
// last cycle of STOP so consecutive bytes run back to back.
module uart_byte_tx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10764
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       stop_end
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    byte_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       sh_q, sh_d;
    logic             tx_q, tx_d;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_MAX);
    assign tx      = tx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BT_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + CNT_W'(1);
        bit_d    = bit_q;
        sh_d     = sh_q;
        tx_d     = tx_q;
        in_ready = 1'b0;
        stop_end = 1'b0;
        case (state_q)
            BT_IDLE: begin
                in_ready = 1'b1;
                cnt_d    = '0;
                tx_d     = 1'b1;
                if (in_valid) begin
                    sh_d    = in_data;
                    tx_d    = 1'b0;
                    state_d = BT_START;
                end
            end
            BT_START: begin
                if (bit_end) begin
                    state_d = BT_DATA;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end
            end
            BT_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = BT_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        tx_d  = sh_q[1];
                    end
                end
            end
            BT_STOP: begin
                if (bit_end) begin
                    stop_end = 1'b1;
                    in_ready = 1'b1;
                    if (in_valid) begin
                        sh_d    = in_data;
                        tx_d    = 1'b0;
                        state_d = BT_START;
                    end else begin
                        state_d = BT_IDLE;
                    end
                end
            end
            default: state_d = BT_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// Badge UART command transmitter: sends mode, arg, mode then an idle gap.
// Define UART_CMD_TX_CHECKSUM_EN to append a checksum byte (4-byte frame).
module uart_cmd_tx
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10764,
    parameter int unsigned GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_mode,
    input  logic [7:0] cmd_arg,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam int unsigned GAP_W = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    seq_state_t       seq_q, seq_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       mode_q, mode_d;
    logic [7:0]       arg_q, arg_d;
    logic [CNT_W-1:0] gtick_q, gtick_d;
    logic [GAP_W-1:0] gbit_q, gbit_d;
    logic             fd_q, fd_d;

    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             stop_end;

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk     (clk),
        .reset_n (reset_n),
        .in_valid(byte_valid),
        .in_data (byte_data),
        .in_ready(byte_ready),
        .tx      (tx),
        .stop_end(stop_end)
    );

    assign cmd_ready  = (seq_q == SEQ_IDLE);
    assign busy       = (seq_q != SEQ_IDLE);
    assign frame_done = fd_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q   <= SEQ_IDLE;
            idx_q   <= '0;
            mode_q  <= '0;
            arg_q   <= '0;
            gtick_q <= '0;
            gbit_q  <= '0;
            fd_q    <= 1'b0;
        end else begin
            seq_q   <= seq_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
            arg_q   <= arg_d;
            gtick_q <= gtick_d;
            gbit_q  <= gbit_d;
            fd_q    <= fd_d;
        end
    end

    always_comb begin
        seq_d      = seq_q;
        idx_d      = idx_q;
        mode_d     = mode_q;
        arg_d      = arg_q;
        gtick_d    = gtick_q;
        gbit_d     = gbit_q;
        fd_d       = 1'b0;
        byte_valid = 1'b0;
        byte_data  = '0;
        case (seq_q)
            SEQ_IDLE: begin
                // First byte goes straight from the port so tx falls right after accept.
                byte_valid = cmd_valid;
                byte_data  = cmd_mode;
                if (cmd_valid) begin
                    mode_d = cmd_mode;
                    arg_d  = cmd_arg;
                    idx_d  = 3'd1;
                    seq_d  = SEQ_SEND;
                end
            end
            SEQ_SEND: begin
                byte_valid = (idx_q < 3'(FRAME_LEN));
                byte_data  = frame_byte(idx_q, mode_q, arg_q);
                if (byte_valid && byte_ready) begin
                    idx_d = idx_q + 3'd1;
                end
                if (stop_end && !byte_valid) begin
                    fd_d    = 1'b1;
                    gtick_d = '0;
                    gbit_d  = '0;
                    seq_d   = (GAP_BITS == 0) ? SEQ_IDLE : SEQ_GAP;
                end
            end
            SEQ_GAP: begin
                gtick_d = gtick_q + CNT_W'(1);
                if (gtick_q == CNT_MAX) begin
                    gtick_d = '0;
                    if (gbit_q == GAP_MAX) begin
                        gbit_d = '0;
                        seq_d  = SEQ_IDLE;
                    end else begin
                        gbit_d = gbit_q + GAP_W'(1);
                    end
                end
            end
            default: seq_d = SEQ_IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_cmd_tx.sv
// Self-checking bench for uart_cmd_tx (GAP_BITS=2 and GAP_BITS=0 instances).
module tb_uart_cmd_tx;

    localparam int CPB = 4;
    localparam int GAP = 2;
`ifdef UART_CMD_TX_CHECKSUM_EN
    localparam int LEN = 4;
`else
    localparam int LEN = 3;
`endif
    localparam int FRAME_CYC = LEN * 10 * CPB;
    localparam int GAP_CYC   = GAP * CPB;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_valid, cmd_ready, tx, busy, frame_done;
    logic [7:0] cmd_mode, cmd_arg;
    logic       valid0, ready0, tx0, busy0, fd0;
    logic [7:0] mode0, arg0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(GAP)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_mode(cmd_mode), .cmd_arg(cmd_arg), .tx(tx), .busy(busy),
        .frame_done(frame_done)
    );

    uart_cmd_tx #(.CLKS_PER_BIT(CPB), .GAP_BITS(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(valid0), .cmd_ready(ready0),
        .cmd_mode(mode0), .cmd_arg(arg0), .tx(tx0), .busy(busy0),
        .frame_done(fd0)
    );

    typedef struct {
        logic [7:0] mode;
        logic [7:0] arg;
        int         chg_k;
        logic [7:0] new_mode;
        logic [7:0] new_arg;
        logic [7:0] exp_mode;
        logic [7:0] exp_arg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Line level at cycle k after the accept edge, from the 8N1 frame definition.
    function automatic logic model_tx(input logic [7:0] m, input logic [7:0] a, input int k);
        logic [7:0] b [4];
        int idx, pos;
        b[0] = m; b[1] = a; b[2] = m; b[3] = m ^ a ^ m;
        if (k >= FRAME_CYC) return 1'b1;
        idx = k / (10 * CPB);
        pos = (k % (10 * CPB)) / CPB;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return b[idx][pos-1];
    endfunction

    task automatic issue(input logic [7:0] m, input logic [7:0] a);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("ready_wait_timeout", 32'(cmd_ready), 32'd1);
        cmd_mode  = m;
        cmd_arg   = a;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Called just after the accept edge; checks every cycle up to re-entry into IDLE.
    task automatic run_frame(input logic [7:0] em, input logic [7:0] ea, input int chg_k,
                             input logic [7:0] nm, input logic [7:0] na);
        for (int k = 0; k <= FRAME_CYC + GAP_CYC; k++) begin
            @(negedge clk);
            if (k == chg_k) begin
                cmd_mode = nm;
                cmd_arg  = na;
            end
            if (k < FRAME_CYC + GAP_CYC) begin
                chk($sformatf("tx@%0d", k), 32'(tx), 32'(model_tx(em, ea, k)));
                chk($sformatf("busy@%0d", k), 32'(busy), 32'd1);
                chk($sformatf("ready@%0d", k), 32'(cmd_ready), 32'd0);
                chk($sformatf("frame_done@%0d", k), 32'(frame_done), 32'(k == FRAME_CYC));
            end else begin
                chk("end_tx", 32'(tx), 32'd1);
                chk("end_busy", 32'(busy), 32'd0);
                chk("end_ready", 32'(cmd_ready), 32'd1);
                chk("end_frame_done", 32'(frame_done), 32'd0);
            end
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        vecs[0] = '{8'h41, 8'h43, -1, 8'h00, 8'h00, 8'h41, 8'h43};
        vecs[1] = '{8'h41, 8'h60, -1, 8'h00, 8'h00, 8'h41, 8'h60};
        vecs[2] = '{8'h42, 8'h00, -1, 8'h00, 8'h00, 8'h42, 8'h00};
        vecs[3] = '{8'h41, 8'h43, 50, 8'h41, 8'h44, 8'h41, 8'h43};
        vecs[4] = '{8'hFF, 8'hA5, 7,  8'h00, 8'h00, 8'hFF, 8'hA5};
        vecs[5] = '{8'h41, 8'h45, -1, 8'h00, 8'h00, 8'h41, 8'h45};

        reset_n = 1'b0; cmd_valid = 1'b0; cmd_mode = '0; cmd_arg = '0;
        valid0 = 1'b0; mode0 = '0; arg0 = '0;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        // Accept on the very first edge after reset release.
        cmd_mode = 8'h41; cmd_arg = 8'h42; cmd_valid = 1'b1;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        run_frame(8'h41, 8'h42, -1, 8'h00, 8'h00);

        foreach (vecs[i]) begin
            issue(vecs[i].mode, vecs[i].arg);
            run_frame(vecs[i].exp_mode, vecs[i].exp_arg, vecs[i].chg_k,
                      vecs[i].new_mode, vecs[i].new_arg);
        end

        for (int r = 0; r < 6; r++) begin
            logic [7:0] m, a, nm, na;
            int ck;
            m  = 8'($urandom);
            a  = 8'($urandom);
            nm = 8'($urandom);
            na = 8'($urandom);
            ck = int'($urandom_range(0, FRAME_CYC - 1));
            issue(m, a);
            run_frame(m, a, ck, nm, na);
        end

        // cmd_valid held high: inputs change mid-frame, second capture only in IDLE.
        cmd_mode = 8'h41; cmd_arg = 8'h43; cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        run_frame(8'h41, 8'h43, 5, 8'h42, 8'h55);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        run_frame(8'h42, 8'h55, -1, 8'h42, 8'h55);

        // Mid-frame asynchronous reset during DATA of byte 1.
        issue(8'h41, 8'h43);
        repeat (12) @(negedge clk);
        chk("pre_reset_tx", 32'(tx), 32'(model_tx(8'h41, 8'h43, 11)));
        chk("pre_reset_busy", 32'(busy), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(cmd_ready), 32'd1);
        chk("async_rst_frame_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_tx@%0d", k), 32'(tx), 32'd1);
            chk($sformatf("post_rst_busy@%0d", k), 32'(busy), 32'd0);
        end
        issue(8'h41, 8'h60);
        run_frame(8'h41, 8'h60, -1, 8'h00, 8'h00);

        // GAP_BITS=0: cmd_ready returns on the frame_done cycle.
        mode0 = 8'h41; arg0 = 8'h43; valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0;
        for (int k = 0; k <= FRAME_CYC; k++) begin
            @(negedge clk);
            chk($sformatf("g0_tx@%0d", k), 32'(tx0), 32'(model_tx(8'h41, 8'h43, k)));
            chk($sformatf("g0_frame_done@%0d", k), 32'(fd0), 32'(k == FRAME_CYC));
            chk($sformatf("g0_ready@%0d", k), 32'(ready0), 32'(k == FRAME_CYC));
            chk($sformatf("g0_busy@%0d", k), 32'(busy0), 32'(k != FRAME_CYC));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
